// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier retiring STEP multiplier bits per cycle, 2N-bit product.
// Signed operand support is compiled in only when MULTIPLIER_SEQ_SIGNED_EN is defined.
module multiplier_seq #(
    parameter int unsigned N    = 32,
    parameter int unsigned STEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] m,
    output logic           busy
);

    localparam int unsigned W      = 2 * N;
    localparam int unsigned CYCLES = N / STEP;
    localparam int unsigned CW     = $clog2(CYCLES + 1);

    if (N < 2) begin : g_bad_n
        $error("multiplier_seq: N must be at least 2");
    end
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || (N % STEP) != 0) begin : g_bad_step
        $error("multiplier_seq: STEP must be 1, 2, 4 or 8 and divide N");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_next;
    logic [W-1:0]   mcand;
    logic [W-1:0]   a_ext;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  count;
    logic           accept;
    logic           last;
    logic           neg_msb;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
    logic b_sgn;

    assign a_ext   = a_signed ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    // A signed multiplier's top bit carries weight -2^(N-1): subtract it on the final digit.
    assign neg_msb = last && b_sgn;
`else
    logic unused_flags;

    assign unused_flags = a_signed ^ b_signed;
    assign a_ext        = {{N{1'b0}}, a};
    assign neg_msb      = 1'b0;
`endif

    assign accept = (state == IDLE) && in_valid;
    assign last   = (count == '0);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_next = acc;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (mplier[i]) begin
                if (neg_msb && (i == STEP - 1)) acc_next = acc_next - (mcand << i);
                else                            acc_next = acc_next + (mcand << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            m      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
            b_sgn  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                acc    <= '0;
                mcand  <= a_ext;
                mplier <= b;
                count  <= CW'(CYCLES - 1);
`ifdef MULTIPLIER_SEQ_SIGNED_EN
                b_sgn  <= b_signed;
`endif
            end else if (state == BUSY) begin
                acc    <= acc_next;
                mcand  <= mcand << STEP;
                mplier <= mplier >> STEP;
                count  <= count - CW'(1);
                if (last) m <= acc_next;
            end
        end
    end

endmodule
